// File: rtl/traffic_seq_ctrl.sv
// Traffic-light sequencer for a four-way junction with a pedestrian phase.
// It drives an external 10-bit countdown timer via load/data_load and advances
// on the timer's terminal-count flag.
//
// Every non-IDLE phase spends one LOAD cycle, which strobes the timer, and then
// a number of WAIT cycles that last until tc is seen.
//
// Ports:
//   clk        - single clock, all state changes on posedge
//   reset      - asynchronous, active-high reset
//   enable     - 1 = cycle the lights, 0 = park in IDLE at the next phase end
//   ped_req    - pedestrian request, latched into ped_pending
//   tc         - terminal count from the countdown timer
//   load       - one-cycle load strobe to the timer
//   data_load  - count value for the timer (zero unless load is high)
//   ns_light   - north-south lamps, one-hot {red,yellow,green}
//   ew_light   - east-west lamps, one-hot {red,yellow,green}
//   walk       - pedestrian walk lamp
//   phase      - phase code (0 IDLE .. 7 WALK)
//   busy       - high in every phase except IDLE
module traffic_seq_ctrl #(
  parameter logic [9:0] T_GREEN  = 10'd20,
  parameter logic [9:0] T_YELLOW = 10'd4,
  parameter logic [9:0] T_RED    = 10'd2,
  parameter logic [9:0] T_WALK   = 10'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ped_req,
  input  logic       tc,
  output logic       load,
  output logic [9:0] data_load,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase,
  output logic       busy
);

  typedef enum logic [2:0] {
    PhIdle = 3'd0,
    PhNsg  = 3'd1,
    PhNsy  = 3'd2,
    PhAr1  = 3'd3,
    PhEwg  = 3'd4,
    PhEwy  = 3'd5,
    PhAr2  = 3'd6,
    PhWalk = 3'd7
  } phase_e;

  localparam logic [2:0] LampR = 3'b100;
  localparam logic [2:0] LampY = 3'b010;
  localparam logic [2:0] LampG = 3'b001;

  phase_e     phase_q, phase_d;
  logic       in_load_q, in_load_d;
  logic       ped_pending_q, ped_pending_d;
  logic       load_q, load_d;
  logic [9:0] data_load_q, data_load_d;
  logic [2:0] ns_q, ns_d;
  logic [2:0] ew_q, ew_d;
  logic       walk_q, walk_d;
  logic       busy_q, busy_d;
  phase_e     seq_next;

  // The phase that follows the current one when its timer expires.
  always_comb begin
    seq_next = PhIdle;
    if (enable) begin
      case (phase_q)
        PhNsg:   seq_next = PhNsy;
        PhNsy:   seq_next = PhAr1;
        PhAr1:   seq_next = PhEwg;
        PhEwg:   seq_next = PhEwy;
        PhEwy:   seq_next = PhAr2;
        PhAr2:   seq_next = ped_pending_q ? PhWalk : PhNsg;
        PhWalk:  seq_next = PhAr1;
        default: seq_next = PhNsg;
      endcase
    end else begin
      // A yellow always passes through all-red before parking.
      if (phase_q == PhNsy) begin
        seq_next = PhAr1;
      end else if (phase_q == PhEwy) begin
        seq_next = PhAr2;
      end else begin
        seq_next = PhIdle;
      end
    end
  end

  // Phase and sub-state. tc is stale in IDLE and in LOAD, so it is ignored there.
  always_comb begin
    phase_d   = phase_q;
    in_load_d = 1'b0;
    if (phase_q == PhIdle) begin
      if (enable) begin
        phase_d   = PhNsg;
        in_load_d = 1'b1;
      end
    end else if (in_load_q) begin
      in_load_d = 1'b0;
    end else if (tc) begin
      phase_d   = seq_next;
      in_load_d = (seq_next != PhIdle);
    end
  end

  // The request is cleared both on the edge entering WALK LOAD and during that
  // LOAD cycle, so a press while the walk is starting is absorbed by it.
  always_comb begin
    ped_pending_d = ped_pending_q | ped_req;
    if ((phase_d == PhWalk && in_load_d) || (phase_q == PhWalk && in_load_q)) begin
      ped_pending_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they change together with the phase register.
  always_comb begin
    load_d      = in_load_d;
    data_load_d = '0;
    ns_d        = LampR;
    ew_d        = LampR;
    walk_d      = 1'b0;
    busy_d      = (phase_d != PhIdle);
    case (phase_d)
      PhNsg: begin
        ns_d = LampG;
        if (in_load_d) data_load_d = T_GREEN;
      end
      PhNsy: begin
        ns_d = LampY;
        if (in_load_d) data_load_d = T_YELLOW;
      end
      PhEwg: begin
        ew_d = LampG;
        if (in_load_d) data_load_d = T_GREEN;
      end
      PhEwy: begin
        ew_d = LampY;
        if (in_load_d) data_load_d = T_YELLOW;
      end
      PhAr1, PhAr2: begin
        if (in_load_d) data_load_d = T_RED;
      end
      PhWalk: begin
        walk_d = 1'b1;
        if (in_load_d) data_load_d = T_WALK;
      end
      default: begin
        data_load_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= PhIdle;
      in_load_q     <= 1'b0;
      ped_pending_q <= 1'b0;
      load_q        <= 1'b0;
      data_load_q   <= '0;
      ns_q          <= LampR;
      ew_q          <= LampR;
      walk_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      in_load_q     <= in_load_d;
      ped_pending_q <= ped_pending_d;
      load_q        <= load_d;
      data_load_q   <= data_load_d;
      ns_q          <= ns_d;
      ew_q          <= ew_d;
      walk_q        <= walk_d;
      busy_q        <= busy_d;
    end
  end

  assign load      = load_q;
  assign data_load = data_load_q;
  assign ns_light  = ns_q;
  assign ew_light  = ew_q;
  assign walk      = walk_q;
  assign phase     = phase_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_traffic_seq_ctrl.sv
// Directed bench for traffic_seq_ctrl with short phase counts and a
// behavioural countdown timer in place of the real one.
module tb_traffic_seq_ctrl;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       ped_req;
  logic       tc;
  logic       load;
  logic [9:0] data_load;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] phase;
  logic       busy;

  int checks = 0;
  int errors = 0;

  traffic_seq_ctrl #(
    .T_GREEN  (10'd3),
    .T_YELLOW (10'd1),
    .T_RED    (10'd0),
    .T_WALK   (10'd2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ped_req   (ped_req),
    .tc        (tc),
    .load      (load),
    .data_load (data_load),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .walk      (walk),
    .phase     (phase),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Countdown timer: loads on strobe, decrements to zero, tc while at zero.
  logic [9:0] tmr = '0;
  always @(posedge clk) begin
    if (load) tmr <= data_load;
    else if (tmr != 10'd0) tmr <= tmr - 10'd1;
  end
  assign tc = (tmr == 10'd0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle safety properties.
  logic prev_load = 1'b0;
  always @(negedge clk) begin
    check_eq("ns_onehot", 32'($onehot(ns_light)), 32'd1);
    check_eq("ew_onehot", 32'($onehot(ew_light)), 32'd1);
    check_eq("both_go", 32'(ns_light != R && ew_light != R), 32'd0);
    check_eq("load_twice", 32'(load && prev_load), 32'd0);
    prev_load = load;
  end

  // Called at the negedge of a phase's LOAD cycle; returns at the negedge of
  // the first cycle of the following phase. ped_at (1-based cycle, 0 = none)
  // raises ped_req for that one cycle.
  task automatic expect_phase(input string tag, input logic [2:0] ph, input int n,
                              input logic [2:0] ns, input logic [2:0] ew, input logic wk,
                              input logic [9:0] dl, input int ped_at);
    int cnt;
    int guard;
    check_eq({tag, "_phase"}, 32'(phase), 32'(ph));
    check_eq({tag, "_load"}, 32'(load), 32'd1);
    check_eq({tag, "_data"}, 32'(data_load), 32'(dl));
    check_eq({tag, "_ns"}, 32'(ns_light), 32'(ns));
    check_eq({tag, "_ew"}, 32'(ew_light), 32'(ew));
    check_eq({tag, "_walk"}, 32'(walk), 32'(wk));
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    cnt = 1;
    guard = 0;
    ped_req = (ped_at == 1);
    while (guard < 1100) begin
      @(negedge clk);
      ped_req = 1'b0;
      guard++;
      if (phase != ph) break;
      cnt++;
      ped_req = (cnt == ped_at);
      check_eq({tag, "_wait_load"}, 32'(load), 32'd0);
      check_eq({tag, "_wait_data"}, 32'(data_load), 32'd0);
      check_eq({tag, "_wait_walk"}, 32'(walk), 32'(wk));
    end
    check_eq({tag, "_len"}, 32'(cnt), 32'(n));
  endtask

  task automatic expect_idle(input string tag);
    check_eq({tag, "_phase"}, 32'(phase), 32'd0);
    check_eq({tag, "_load"}, 32'(load), 32'd0);
    check_eq({tag, "_data"}, 32'(data_load), 32'd0);
    check_eq({tag, "_ns"}, 32'(ns_light), 32'(R));
    check_eq({tag, "_ew"}, 32'(ew_light), 32'(R));
    check_eq({tag, "_walk"}, 32'(walk), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    ped_req = 1'b0;
    repeat (3) @(negedge clk);
    expect_idle("rst");

    reset = 1'b0;
    enable = 1'b1;
    @(negedge clk);

    // First round, pedestrian press during EWG.
    expect_phase("nsg1", 3'd1, 5, G, R, 1'b0, 10'd3, 0);
    expect_phase("nsy1", 3'd2, 3, Y, R, 1'b0, 10'd1, 0);
    expect_phase("ar1a", 3'd3, 2, R, R, 1'b0, 10'd0, 0);
    expect_phase("ewg1", 3'd4, 5, R, G, 1'b0, 10'd3, 2);
    expect_phase("ewy1", 3'd5, 3, R, Y, 1'b0, 10'd1, 0);
    expect_phase("ar2a", 3'd6, 2, R, R, 1'b0, 10'd0, 0);
    // Press again during WALK LOAD: must be absorbed.
    expect_phase("walk1", 3'd7, 4, R, R, 1'b1, 10'd2, 1);
    expect_phase("ar1b", 3'd3, 2, R, R, 1'b0, 10'd0, 0);
    expect_phase("ewg2", 3'd4, 5, R, G, 1'b0, 10'd3, 0);
    expect_phase("ewy2", 3'd5, 3, R, Y, 1'b0, 10'd1, 0);
    expect_phase("ar2b", 3'd6, 2, R, R, 1'b0, 10'd0, 0);
    expect_phase("nsg2", 3'd1, 5, G, R, 1'b0, 10'd3, 0);

    // Drop enable at the start of NSY: NSY and AR1 complete, then IDLE.
    enable = 1'b0;
    expect_phase("nsy2", 3'd2, 3, Y, R, 1'b0, 10'd1, 0);
    expect_phase("ar1c", 3'd3, 2, R, R, 1'b0, 10'd0, 0);
    expect_idle("idle1");
    repeat (2) @(negedge clk);
    expect_idle("idle2");

    // Press while parked; it must survive IDLE and produce a WALK.
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    @(negedge clk);
    expect_idle("idle3");
    enable = 1'b1;
    @(negedge clk);
    expect_phase("nsg3", 3'd1, 5, G, R, 1'b0, 10'd3, 0);
    expect_phase("nsy3", 3'd2, 3, Y, R, 1'b0, 10'd1, 0);
    expect_phase("ar1d", 3'd3, 2, R, R, 1'b0, 10'd0, 0);
    expect_phase("ewg3", 3'd4, 5, R, G, 1'b0, 10'd3, 0);
    expect_phase("ewy3", 3'd5, 3, R, Y, 1'b0, 10'd1, 0);
    expect_phase("ar2c", 3'd6, 2, R, R, 1'b0, 10'd0, 0);
    expect_phase("walk2", 3'd7, 4, R, R, 1'b1, 10'd2, 0);
    expect_phase("ar1e", 3'd3, 2, R, R, 1'b0, 10'd0, 0);

    // Now in EWG LOAD; assert reset between edges mid-EWG.
    check_eq("ewg4_phase", 32'(phase), 32'd4);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 expect_idle("async_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    expect_phase("nsg4", 3'd1, 5, G, R, 1'b0, 10'd3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
